// File: rtl/level_progress_tracker.sv
// level_progress_tracker: per-level countdown, win/loss decision, level counter
// and menu confirm pulses feeding the stage controller's stageEnded/playerWon pair.
module level_progress_tracker #(
    parameter int FRAMES_PER_SEC = 30,
    parameter int LEVEL_SECONDS  = 60,
    parameter int BASE_TARGET    = 650,
    parameter int TARGET_STEP    = 275,
    parameter int MAX_LEVEL      = 15
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [3:0]  stage,
    input  logic [15:0] score,
    input  logic        levelCleared,
    input  logic        confirmKey,
    output logic        stageEnded,
    output logic        playerWon,
    output logic [6:0]  secondsLeft,
    output logic [3:0]  level,
    output logic [15:0] targetScore
);
    localparam int FW = FRAMES_PER_SEC > 1 ? $clog2(FRAMES_PER_SEC) : 1;
    typedef enum logic [1:0] {LEVEL_RUN, LEVEL_DONE, MENU} modeT;
    modeT mode;
    logic [FW-1:0] frameCnt;
    logic [3:0] prevStage;
    logic [16:0] targetWide;
    logic done, confirmPrev, entry, tick, secWrap, levelEnd, won, confirmEdge;
    always_comb begin
        targetWide = 17'(BASE_TARGET) + 17'(level) * 17'(TARGET_STEP);
        targetScore = targetWide[16] ? 16'hFFFF : targetWide[15:0];
        mode = stage != 4'd0 ? MENU : done ? LEVEL_DONE : LEVEL_RUN;
        entry = stage == 4'd0 && prevStage != 4'd0;
        // entry load wins over a frame tick landing on the same cycle
        tick = mode == LEVEL_RUN && !entry && startOfFrame;
        secWrap = frameCnt == FW'(FRAMES_PER_SEC - 1);
        levelEnd = tick && ((secWrap && secondsLeft == 7'd1) || levelCleared);
        won = score >= targetScore;
        confirmEdge = mode == MENU && confirmKey && !confirmPrev;
    end
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            stageEnded  <= 1'b0;
            playerWon   <= 1'b0;
            secondsLeft <= 7'(LEVEL_SECONDS);
            level       <= 4'd0;
            frameCnt    <= '0;
            done        <= 1'b0;
            prevStage   <= 4'd4;
            confirmPrev <= 1'b0;
        end else begin
            stageEnded  <= levelEnd || confirmEdge;
            playerWon   <= levelEnd ? won : playerWon;
            done        <= entry ? 1'b0 : levelEnd ? 1'b1 : done;
            frameCnt    <= entry ? '0 : tick ? (secWrap ? '0 : frameCnt + FW'(1)) : frameCnt;
            secondsLeft <= entry ? 7'(LEVEL_SECONDS) : (tick && secWrap) ? secondsLeft - 7'd1 : secondsLeft;
            level       <= stage == 4'd4 ? 4'd0 :
                           (levelEnd && won && level < 4'(MAX_LEVEL)) ? level + 4'd1 : level;
            prevStage   <= stage;
            confirmPrev <= confirmKey;
        end
    end
endmodule

// File: tb/tb_level_progress_tracker.sv
// tb_level_progress_tracker: frame-count reference model checked every cycle,
// directed scenarios with literal expectations, then randomized stages.
module tb_level_progress_tracker;
    localparam int FPS = 30, LS = 40, BASE = 650, STEP = 275, MAXL = 15;
    logic clk = 1'b0, resetN = 1'b0, startOfFrame = 1'b0, levelCleared = 1'b0, confirmKey = 1'b0;
    logic [3:0] stage = 4'd4;
    logic [15:0] score = 16'd0;
    logic stageEnded, playerWon;
    logic [6:0] secondsLeft;
    logic [3:0] level;
    logic [15:0] targetScore;
    int vectors = 0, miscompares = 0, pulses = 0;
    int mLevel = 0, mFrames = 0, mPrevStage = 4;
    bit mDone = 0, mPrevKey = 0, mEnded = 0, mWon = 0;

    level_progress_tracker #(
        .FRAMES_PER_SEC(FPS), .LEVEL_SECONDS(LS), .BASE_TARGET(BASE),
        .TARGET_STEP(STEP), .MAX_LEVEL(MAXL)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .stage(stage),
        .score(score), .levelCleared(levelCleared), .confirmKey(confirmKey),
        .stageEnded(stageEnded), .playerWon(playerWon), .secondsLeft(secondsLeft),
        .level(level), .targetScore(targetScore)
    );

    always #5 clk = ~clk;

    function automatic int mTarget(input int lv);
        return (BASE + lv * STEP > 65535) ? 65535 : BASE + lv * STEP;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mLevel = 0; mFrames = 0; mPrevStage = 4;
        mDone = 0; mPrevKey = 0; mEnded = 0; mWon = 0;
    endtask

    // elapsed frames since entry drive both the remaining seconds and the timeout
    task automatic advance();
        int tgt;
        bit e;
        tgt = mTarget(mLevel);
        e = 0;
        if (stage == 0 && mPrevStage != 0) begin
            mFrames = 0;
            mDone = 0;
        end else if (stage == 0) begin
            if (!mDone && startOfFrame) begin
                mFrames++;
                if (mFrames == LS * FPS || levelCleared) begin
                    e = 1;
                    mWon = int'(score) >= tgt;
                    mDone = 1;
                    if (mWon && mLevel < MAXL) mLevel++;
                end
            end
        end else e = confirmKey && !mPrevKey;
        if (stage == 4) mLevel = 0;
        mEnded = e;
        mPrevStage = int'(stage);
        mPrevKey = confirmKey;
    endtask

    task automatic cyc(input int st, input bit sof, input int sc, input bit clr, input bit key);
        stage = 4'(st); startOfFrame = sof; score = 16'(sc); levelCleared = clr; confirmKey = key;
        @(posedge clk);
        #1;
        if (resetN) advance(); else modelReset();
    endtask

    always @(negedge clk) begin
        check("stageEnded", stageEnded, mEnded);
        check("playerWon", playerWon, mWon);
        check("secondsLeft", secondsLeft, LS - mFrames / FPS);
        check("level", level, mLevel);
        check("targetScore", targetScore, mTarget(mLevel));
        if (stageEnded === 1'b1) pulses++;
    end

    initial begin
        int st, hold;
        repeat (3) cyc(4, 0, 0, 0, 0);
        check("rst_seconds", secondsLeft, 40);
        check("rst_level", level, 0);
        check("rst_target", targetScore, 650);
        check("rst_ended", stageEnded, 0);
        resetN = 1'b1;
        repeat (2) cyc(4, 0, 0, 0, 0);
        pulses = 0;
        repeat (LS * FPS + 6) cyc(0, 1, 700, 0, 0);
        check("timeout_pulses", pulses, 1);
        check("timeout_won", playerWon, 1);
        check("timeout_level", level, 1);
        check("timeout_target", targetScore, 925);
        repeat (3) cyc(2, 0, 0, 0, 0);
        pulses = 0;
        repeat (LS * FPS + 6) cyc(0, 1, 900, 0, 0);
        check("loss_pulses", pulses, 1);
        check("loss_won", playerWon, 0);
        check("loss_level", level, 1);
        repeat (3) cyc(1, 0, 0, 0, 0);
        pulses = 0;
        cyc(0, 0, 2000, 0, 0);
        repeat (LS * FPS - 1) cyc(0, 1, 2000, 0, 0);
        cyc(0, 1, 2000, 1, 0);
        repeat (5) cyc(0, 1, 2000, 1, 0);
        check("clear_pulses", pulses, 1);
        check("clear_won", playerWon, 1);
        check("clear_level", level, 2);
        check("clear_seconds", secondsLeft, 0);
        cyc(1, 0, 0, 0, 0);
        pulses = 0;
        repeat (10) cyc(1, 0, 0, 0, 1);
        repeat (2) cyc(1, 0, 0, 0, 0);
        check("confirm_pulses", pulses, 1);
        pulses = 0;
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, i % 2 == 0);
        repeat (2) cyc(0, 0, 0, 0, 0);
        check("level_key_pulses", pulses, 0);
        repeat (16) begin
            cyc(1, 0, 0, 0, 0);
            cyc(0, 0, 65535, 0, 0);
            cyc(0, 1, 65535, 1, 0);
            cyc(0, 0, 65535, 0, 0);
        end
        check("sat_level", level, 15);
        check("sat_target", targetScore, 4775);
        hold = 0;
        st = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
                hold = int'($urandom_range(1, 300));
            end
            hold--;
            cyc(st, $urandom_range(0, 1) == 1, int'($urandom_range(0, 65535)),
                $urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1);
        end
        repeat (2) cyc(4, 0, 0, 0, 0);
        check("menu_level", level, 0);
        check("menu_target", targetScore, 650);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        repeat (3 * FPS) cyc(0, 1, 0, 0, 0);
        check("pre_rst_seconds", secondsLeft, 37);
        #1;
        resetN = 1'b0;
        modelReset();
        #1;
        check("async_seconds", secondsLeft, 40);
        check("async_ended", stageEnded, 0);
        check("async_level", level, 0);
        repeat (3) cyc(0, 1, 0, 0, 0);
        resetN = 1'b1;
        pulses = 0;
        repeat (5) cyc(0, 1, 0, 0, 0);
        check("release_pulses", pulses, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/level_progress_tracker.md
# level_progress_tracker

Sits directly upstream of the game stage controller and produces its `stageEnded` / `playerWon` pair. In the level stage it runs the per-level countdown from frame ticks, holds the level's target score and decides win or loss. In every non-level stage it turns a confirm key press into a stage-end pulse. It also owns the level number, which sets the target score and is exported for display.

## Interface
Parameters:
- FRAMES_PER_SEC, 30, startOfFrame pulses per countdown second
- LEVEL_SECONDS, 60, countdown loaded on level entry (1..127)
- BASE_TARGET, 650, target score of level 0
- TARGET_STEP, 275, target increase per level
- MAX_LEVEL, 15, level counter saturation value

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-clk pulse per frame
- stage  in  4  current stage: 0 level, 1 shop, 2 win menu, 3 loss menu, 4 main menu, 5 game end
- score  in  16  player's accumulated score, unsigned
- levelCleared  in  1  level, all collectible objects taken
- confirmKey  in  1  debounced, synchronous key level
- stageEnded  out  1  one-clk pulse requesting stage advance
- playerWon  out  1  result qualifier, valid with stageEnded, held until next pulse
- secondsLeft  out  7  countdown value for HUD
- level  out  4  current level index
- targetScore  out  16  score needed to win current level

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: stageEnded 0, playerWon 0, secondsLeft LEVEL_SECONDS, level 0, frame counter 0, done latch 0, prevStage 4, confirm history 0.
- Target score: targetScore = BASE_TARGET + level*TARGET_STEP, computed at 17 bits and saturated to 0xFFFF. It is a combinational function of the level register.
- Level entry: when stage==0 and prevStage!=0, load secondsLeft=LEVEL_SECONDS, clear the frame counter and clear done. prevStage is registered every clk.
- Countdown states: LEVEL_RUN (stage 0, done=0), LEVEL_DONE (stage 0, done=1), MENU (stage≠0).
- In LEVEL_RUN, on each startOfFrame:
  - if frameCnt==FRAMES_PER_SEC-1, frameCnt←0 and secondsLeft←secondsLeft-1;
  - otherwise frameCnt increments.
- End conditions in LEVEL_RUN: the stage ends on a startOfFrame cycle where either of these holds.
  - Timeout: the decrement takes secondsLeft to 0.
  - Clear: levelCleared is sampled high.
- Level end actions, on that edge:
  - stageEnded←1 for one clk;
  - playerWon←(score ≥ targetScore), using the pre-edge level;
  - done←1.
- Clear and timeout in the same frame produce a single pulse, with playerWon still taken from the score comparison.
- LEVEL_DONE: no counting and no further pulses until the stage changes. The controller sees stage 0 for at least one extra cycle, and the done latch prevents a double fire.
- Level counter: on the level-end edge, if playerWon is computed 1, level←min(level+1, MAX_LEVEL). Any clk with stage==4 forces level←0.
- MENU: a rising edge of confirmKey (confirmKey=1 and previous sample 0) gives stageEnded←1 for one clk. playerWon keeps its previous value. confirmKey is ignored in stage 0.
- secondsLeft holds its value outside stage 0.

## Timing
- stageEnded and playerWon are registered and change on the same edge. The controller samples both in the cycle stageEnded is high.
- Latency: stageEnded is high in the clk after the qualifying startOfFrame or confirm-edge cycle.
- Pulse width is exactly one clk. Back-to-back pulses are impossible: a level needs a new frame after entry, and a confirm needs a new rising edge.
- Reset asserted mid-level: all state returns to reset values immediately. No pulse is issued on release.
- Stage change arriving on the same cycle as startOfFrame: the level-entry load has priority over counting.
- Entry load is unconditional on each 0-entry. A loss→main-menu→level path therefore restarts at level 0 with full time.

## Test plan
- Timeout with a winning score: reset, stage 4→0, score=700, FRAMES_PER_SEC=30, LEVEL_SECONDS=2, 60 frames → exactly one stageEnded pulse one clk after frame 60, playerWon=1, level 0→1, targetScore 650→925.
- Timeout below target: level 1, score=900 → pulse with playerWon=0, level stays 1.
- Clear and final frame together: levelCleared high on the frame that hits secondsLeft=0 → single pulse. Holding stage=0 for 5 more frames → no second pulse.
- Menu confirm: stage=1, confirmKey held high for 10 clks → exactly one stageEnded pulse. confirmKey toggled during stage 0 → no pulse.
- Saturation and reset: force level 15 with a win → level stays 15 and targetScore = min(650+15·275, 0xFFFF) = 4775. Stage=4 → level 0.
- Async reset mid-countdown at secondsLeft=37 → secondsLeft=60, stageEnded=0 immediately, with no clock edge needed.
